// File: rtl/dev_hex_scan_if.sv
// rtl/dev_hex_scan_if.sv - display data/control and pin bundle for dev_hex_scan
interface dev_hex_scan_if #(
    parameter int NDIGITS = 4
);
    logic [4*NDIGITS-1:0] hex_val;
    logic [NDIGITS-1:0]   dp_in;
    logic                 enable;
    logic                 lz_suppress;
    logic [3:0]           brightness;
    logic [NDIGITS-1:0]   digit_sel;
    logic [6:0]           seg_pins;
    logic                 dp_pin;
    logic                 frame_done;

    modport master (
        output hex_val, dp_in, enable, lz_suppress, brightness,
        input  digit_sel, seg_pins, dp_pin, frame_done
    );

    modport slave (
        input  hex_val, dp_in, enable, lz_suppress, brightness,
        output digit_sel, seg_pins, dp_pin, frame_done
    );
endinterface

// File: rtl/dev_hex_scan.sv
// rtl/dev_hex_scan.sv - multiplexed common-anode 7-segment hex scanner
module dev_hex_scan #(
    parameter int NDIGITS  = 4,
    parameter int PRESCALE = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    dev_hex_scan_if.slave  bus
);
    localparam int IW = (NDIGITS > 1) ? $clog2(NDIGITS) : 1;
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_MAX = PW'(PRESCALE - 1);
    localparam logic [IW-1:0] IDX_MAX  = IW'(NDIGITS - 1);

    // Active-low segment patterns, bit0 = segment a
    function automatic logic [6:0] seg7(input logic [3:0] v);
        logic [6:0] s;
        case (v)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    logic [PW-1:0]          pcnt;
    logic [3:0]             phase;
    logic [IW-1:0]          idx;
    logic [4*NDIGITS-1:0]   shadow_hex;
    logic [NDIGITS-1:0]     shadow_dp;
    logic [NDIGITS-1:0]     digit_sel_q;
    logic [6:0]             seg_q;
    logic                   dp_q;
    logic                   frame_done_q;

    logic                   tick;
    logic [3:0]             phase_nxt;
    logic [IW-1:0]          idx_nxt;
    logic                   latch;
    logic [3:0]             lit_lim;
    logic                   lit_nxt;
    logic [NDIGITS-1:0]     lz_blank;
    logic                   zero_run;
    logic [3:0]             nib;
    logic                   dp_bit;
    logic                   blank_bit;
    logic [NDIGITS-1:0]     sel_nxt;
    logic [6:0]             seg_nxt;
    logic                   dp_nxt;

    assign tick      = (pcnt == PCNT_MAX);
    assign phase_nxt = phase + 4'd1;
    assign idx_nxt   = (phase == 4'd15) ? ((idx == IDX_MAX) ? '0 : idx + IW'(1)) : idx;
    // Shadow captures on the tick leaving the first phase of the frame
    assign latch     = tick && (idx == '0) && (phase == 4'd0);
    assign lit_lim   = (bus.brightness == 4'hF) ? 4'd14 : bus.brightness;
    assign lit_nxt   = (phase_nxt >= 4'd2) && ((phase_nxt - 4'd2) < lit_lim);

    // A digit is a leading zero when it and every digit to its left are zero
    always_comb begin
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = NDIGITS - 1; i >= 0; i--) begin
            zero_run    = zero_run && (shadow_hex[4*i +: 4] == 4'h0);
            lz_blank[i] = zero_run && (i != 0);
        end
    end

    // Select nibble, dp and select bit for the digit of the upcoming phase
    always_comb begin
        nib       = 4'h0;
        dp_bit    = 1'b0;
        blank_bit = 1'b0;
        sel_nxt   = '0;
        for (int i = 0; i < NDIGITS; i++) begin
            if (IW'(i) == idx_nxt) begin
                nib        = shadow_hex[4*i +: 4];
                dp_bit     = shadow_dp[i];
                blank_bit  = lz_blank[i];
                sel_nxt[i] = 1'b1;
            end
        end
        seg_nxt = (lit_nxt && !(bus.lz_suppress && blank_bit)) ? seg7(nib) : 7'h7F;
        dp_nxt  = lit_nxt ? ~dp_bit : 1'b1;
    end

    // Prescaler, phase/digit sequencing, shadow latch and registered pin drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt         <= '0;
            phase        <= 4'd0;
            idx          <= '0;
            shadow_hex   <= '0;
            shadow_dp    <= '0;
            digit_sel_q  <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else if (!bus.enable) begin
            pcnt         <= '0;
            phase        <= 4'd0;
            idx          <= '0;
            digit_sel_q  <= '0;
            seg_q        <= 7'h7F;
            dp_q         <= 1'b1;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (tick) begin
                pcnt  <= '0;
                phase <= phase_nxt;
                idx   <= idx_nxt;
                if (latch) begin
                    shadow_hex <= bus.hex_val;
                    shadow_dp  <= bus.dp_in;
                end
                // BLANK keeps the previous digit selected; every other phase drives the new one
                if (phase_nxt != 4'd0) begin
                    digit_sel_q <= sel_nxt;
                end
                seg_q        <= seg_nxt;
                dp_q         <= dp_nxt;
                frame_done_q <= (phase == 4'd15) && (idx == IDX_MAX);
            end else begin
                pcnt <= pcnt + PW'(1);
            end
        end
    end

    assign bus.digit_sel  = digit_sel_q;
    assign bus.seg_pins   = seg_q;
    assign bus.dp_pin     = dp_q;
    assign bus.frame_done = frame_done_q;
endmodule

// File: tb/tb_dev_hex_scan.sv
// tb/tb_dev_hex_scan.sv - self-checking bench for dev_hex_scan
module tb_dev_hex_scan;
    localparam int N = 4;
    localparam int P = 2;
    localparam int F = 16 * N;

    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    typedef struct {
        logic [3:0] sel;
        logic [6:0] seg;
        logic       dp;
    } out_t;

    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic        lz;
        logic [3:0]  br;
        int          idx;
        logic [6:0]  seg;
        logic        dpp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   cur_k  = 0;

    dev_hex_scan_if #(.NDIGITS(N)) bus ();

    dev_hex_scan #(.NDIGITS(N), .PRESCALE(P)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference: outputs of absolute phase number g since (re)start
    function automatic out_t model_out(input int g, input logic [15:0] hs, input logic [3:0] ds,
                                       input logic [3:0] b, input logic lz);
        out_t o;
        int p, slot, idx, br;
        logic [15:0] upper;
        p    = g % 16;
        slot = g / 16;
        idx  = slot % N;
        br   = (b == 4'd15) ? 14 : int'(b);
        if (p == 0) o.sel = (slot == 0) ? 4'b0000 : 4'(1 << ((slot - 1) % N));
        else        o.sel = 4'(1 << idx);
        upper = hs >> (4 * idx);
        if (p >= 2 && (p - 2) < br) begin
            o.seg = (lz && idx > 0 && upper == 16'h0) ? 7'h7F : SEG_TAB[upper[3:0]];
            o.dp  = ~ds[idx];
        end else begin
            o.seg = 7'h7F;
            o.dp  = 1'b1;
        end
        return o;
    endfunction

    int          mk;
    logic [15:0] m_hex_sh;
    logic [3:0]  m_dp_sh;
    logic [3:0]  m_sel;
    logic [6:0]  m_seg;
    logic        m_dpp;
    logic        m_fd;

    always @(posedge clk or negedge rst_n) begin : model
        int nk, g;
        logic [15:0] hs;
        logic [3:0] ds;
        out_t o;
        if (!rst_n) begin
            mk <= 0; m_hex_sh <= '0; m_dp_sh <= '0;
            m_sel <= '0; m_seg <= 7'h7F; m_dpp <= 1'b1; m_fd <= 1'b0;
        end else if (!bus.enable) begin
            mk <= 0;
            m_sel <= '0; m_seg <= 7'h7F; m_dpp <= 1'b1; m_fd <= 1'b0;
        end else begin
            nk = mk + 1;
            mk <= nk;
            m_fd <= 1'b0;
            if (nk % P == 0) begin
                g  = nk / P;
                hs = m_hex_sh;
                ds = m_dp_sh;
                if (g % F == 1) begin
                    hs = bus.hex_val;
                    ds = bus.dp_in;
                end
                m_hex_sh <= hs;
                m_dp_sh  <= ds;
                o = model_out(g, hs, ds, bus.brightness, bus.lz_suppress);
                m_sel <= o.sel;
                m_seg <= o.seg;
                m_dpp <= o.dp;
                m_fd  <= (g % F == 0);
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: sample at the falling edge and compare every pin with the model
    task automatic cyc();
        @(negedge clk);
        cur_k++;
        checks++;
        if ({bus.digit_sel, bus.seg_pins, bus.dp_pin, bus.frame_done} !== {m_sel, m_seg, m_dpp, m_fd}) begin
            errors++;
            $display("FAIL model t=%0t sel=%b seg=%b dp=%b fd=%b want sel=%b seg=%b dp=%b fd=%b",
                     $time, bus.digit_sel, bus.seg_pins, bus.dp_pin, bus.frame_done,
                     m_sel, m_seg, m_dpp, m_fd);
        end
    endtask

    task automatic restart();
        bus.enable = 1'b0;
        cyc();
        bus.enable = 1'b1;
        cur_k = 0;
    endtask

    task automatic run_to(input int g);
        while (cur_k < P * g) cyc();
    endtask

    vec_t vt [15];

    initial begin
        int cnt, lit, seln;
        bit seen;

        vt[0]  = '{16'h12AF, 4'b0000, 1'b0, 4'd15, 0, 7'b0001110, 1'b1};
        vt[1]  = '{16'h12AF, 4'b0000, 1'b0, 4'd15, 3, 7'b1111001, 1'b1};
        vt[2]  = '{16'h0050, 4'b1000, 1'b1, 4'd14, 3, 7'h7F,      1'b0};
        vt[3]  = '{16'h0050, 4'b1000, 1'b1, 4'd14, 2, 7'h7F,      1'b1};
        vt[4]  = '{16'h0050, 4'b1000, 1'b1, 4'd14, 1, 7'b0010010, 1'b1};
        vt[5]  = '{16'h0050, 4'b1000, 1'b1, 4'd14, 0, 7'b1000000, 1'b1};
        vt[6]  = '{16'h0000, 4'b0000, 1'b1, 4'd14, 0, 7'b1000000, 1'b1};
        vt[7]  = '{16'h0000, 4'b0000, 1'b1, 4'd14, 1, 7'h7F,      1'b1};
        vt[8]  = '{16'h0000, 4'b0000, 1'b0, 4'd14, 2, 7'b1000000, 1'b1};
        vt[9]  = '{16'h89AB, 4'b0100, 1'b0, 4'd5,  2, 7'b0010000, 1'b0};
        vt[10] = '{16'h89AB, 4'b0100, 1'b0, 4'd5,  0, 7'b0000011, 1'b1};
        vt[11] = '{16'h89AB, 4'b0001, 1'b0, 4'd0,  0, 7'h7F,      1'b1};
        vt[12] = '{16'hC0DE, 4'b0000, 1'b1, 4'd9,  2, 7'b1000000, 1'b1};
        vt[13] = '{16'hC0DE, 4'b0000, 1'b1, 4'd9,  3, 7'b1000110, 1'b1};
        vt[14] = '{16'h0034, 4'b0000, 1'b1, 4'd1,  1, 7'b0110000, 1'b1};

        rst_n = 1'b0;
        bus.hex_val = 16'h0; bus.dp_in = 4'h0; bus.enable = 1'b0;
        bus.lz_suppress = 1'b0; bus.brightness = 4'd0;
        repeat (3) cyc();
        check("rst_sel", 32'(bus.digit_sel), 32'h0);
        check("rst_seg", 32'(bus.seg_pins), 32'h7F);
        check("rst_dp", 32'(bus.dp_pin), 32'h1);
        check("rst_fd", 32'(bus.frame_done), 32'h0);
        rst_n = 1'b1;

        // Table vectors: sample the first lit clk of the chosen digit in the second frame
        for (int v = 0; v < 15; v++) begin
            bus.hex_val = vt[v].hex; bus.dp_in = vt[v].dp;
            bus.lz_suppress = vt[v].lz; bus.brightness = vt[v].br;
            restart();
            run_to(F + 16 * vt[v].idx + 2);
            check($sformatf("vec%0d_seg", v), 32'(bus.seg_pins), 32'(vt[v].seg));
            check($sformatf("vec%0d_dp", v), 32'(bus.dp_pin), 32'(vt[v].dpp));
            check($sformatf("vec%0d_sel", v), 32'(bus.digit_sel), 32'(4'b0001 << vt[v].idx));
        end

        // Async reset in the middle of a lit phase, then blank for one tick before switch
        bus.hex_val = 16'h12AF; bus.lz_suppress = 1'b0; bus.brightness = 4'd14;
        restart();
        run_to(2);
        cyc();
        #2 rst_n = 1'b0;
        #1;
        check("midrst_sel", 32'(bus.digit_sel), 32'h0);
        check("midrst_seg", 32'(bus.seg_pins), 32'h7F);
        check("midrst_dp", 32'(bus.dp_pin), 32'h1);
        check("midrst_fd", 32'(bus.frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cur_k = 0;
        repeat (P - 1) cyc();
        check("postrst_blank_sel", 32'(bus.digit_sel), 32'h0);
        cyc();
        check("postrst_switch_sel", 32'(bus.digit_sel), 32'h1);
        check("postrst_switch_seg", 32'(bus.seg_pins), 32'h7F);

        // frame_done period and width
        cnt = 0; seen = 0;
        for (int i = 0; i < 2 * F * P && !seen; i++) begin cyc(); if (bus.frame_done) seen = 1; end
        check("fd_first_seen", 32'(seen), 32'h1);
        cyc();
        check("fd_width", 32'(bus.frame_done), 32'h0);
        cnt = 1; seen = 0;
        for (int i = 0; i < 2 * F * P && !seen; i++) begin cyc(); cnt++; if (bus.frame_done) seen = 1; end
        check("fd_period", 32'(cnt), 32'(F * P));

        // Lit-clock count per frame for brightness 3 and 0
        for (int b = 0; b < 2; b++) begin
            bus.hex_val = 16'h8888; bus.brightness = (b == 0) ? 4'd3 : 4'd0;
            restart();
            run_to(F);
            lit = 0; seln = 0;
            for (int i = 0; i < F * P; i++) begin
                cyc();
                if (bus.seg_pins != 7'h7F) lit++;
                if (bus.digit_sel != 4'h0) seln++;
            end
            check($sformatf("lit_count_b%0d", b), 32'(lit), 32'((b == 0) ? 3 * P * N : 0));
            check($sformatf("sel_count_b%0d", b), 32'(seln), 32'(F * P));
        end

        // Tear-free: change mid frame, the rest of this frame keeps the old value
        bus.hex_val = 16'h1111; bus.brightness = 4'd14;
        restart();
        run_to(F + 32 + 3);
        bus.hex_val = 16'h2222;
        check("tear_idx2_old", 32'(bus.seg_pins), 32'(7'b1111001));
        run_to(F + 48 + 2);
        check("tear_idx3_old", 32'(bus.seg_pins), 32'(7'b1111001));
        run_to(2 * F + 2);
        check("tear_idx0_new", 32'(bus.seg_pins), 32'(7'b0100100));
        run_to(2 * F + 48 + 2);
        check("tear_idx3_new", 32'(bus.seg_pins), 32'(7'b0100100));

        // Enable drop mid slot and restart with fresh latch
        bus.hex_val = 16'h3456;
        restart();
        run_to(16 + 5);
        bus.enable = 1'b0;
        cyc();
        check("en_off_sel", 32'(bus.digit_sel), 32'h0);
        check("en_off_seg", 32'(bus.seg_pins), 32'h7F);
        check("en_off_dp", 32'(bus.dp_pin), 32'h1);
        bus.hex_val = 16'h0007;
        bus.enable = 1'b1;
        cur_k = 0;
        repeat (P - 1) cyc();
        check("en_on_blank", 32'(bus.digit_sel), 32'h0);
        cyc();
        check("en_on_switch", 32'(bus.digit_sel), 32'h1);
        run_to(2);
        check("en_on_newval", 32'(bus.seg_pins), 32'(7'b1111000));

        // Random traffic against the reference
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(19) == 0)
                bus.hex_val = ($urandom_range(1) == 0) ? 16'($urandom_range(255)) : 16'($urandom);
            if ($urandom_range(29) == 0) bus.dp_in = 4'($urandom);
            if ($urandom_range(49) == 0) bus.lz_suppress = ~bus.lz_suppress;
            if ($urandom_range(39) == 0) bus.brightness = 4'($urandom);
            if ($urandom_range(299) == 0) bus.enable = 1'b0;
            else if (!bus.enable && $urandom_range(2) == 0) bus.enable = 1'b1;
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
